// File: rtl/traffic_light_controller.sv
// rtl/traffic_light_controller.sv - fixed-time two-road traffic light sequencer
// Ports: clk     - system clock, all state changes on its rising edge
//        rst     - synchronous active-high reset
//        lightWE - West-East lamps, one-hot: bit2 red, bit1 yellow, bit0 green
//        lightNS - North-South lamps, same encoding
// Build option: TRAFFIC_LIGHT_ALLRED_EN inserts all-red clearance phases
//               (NS_CLR, WE_CLR) after each yellow.
module traffic_light_controller #(
    parameter int GREEN_TIME  = 30,
    parameter int YELLOW_TIME = 5,
    parameter int ALLRED_TIME = 2,
    parameter int TIMER_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] lightWE,
    output logic [2:0] lightNS
);

    // Terminal counts; a zero duration behaves as a one-cycle phase.
    localparam logic [TIMER_W-1:0] GRN_LAST =
        TIMER_W'((GREEN_TIME > 1) ? GREEN_TIME - 1 : 0);
    localparam logic [TIMER_W-1:0] YEL_LAST =
        TIMER_W'((YELLOW_TIME > 1) ? YELLOW_TIME - 1 : 0);
    localparam logic [TIMER_W-1:0] CLR_LAST =
        TIMER_W'((ALLRED_TIME > 1) ? ALLRED_TIME - 1 : 0);

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    typedef enum logic [2:0] {
        NS_GRN = 3'd0,
        NS_YEL = 3'd1,
        NS_CLR = 3'd2,
        WE_GRN = 3'd3,
        WE_YEL = 3'd4,
        WE_CLR = 3'd5
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [TIMER_W-1:0] count;
    logic [TIMER_W-1:0] count_next;
    logic [TIMER_W-1:0] phase_last;
    logic               done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= NS_GRN;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // Duration lookup is shared by both roads.
    always_comb begin
        phase_last = '0;
        case (state)
            NS_GRN, WE_GRN: phase_last = GRN_LAST;
            NS_YEL, WE_YEL: phase_last = YEL_LAST;
            NS_CLR, WE_CLR: phase_last = CLR_LAST;
            default:        phase_last = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        done       = (count == phase_last);
        count_next = done ? '0 : count + 1'b1;
        case (state)
            NS_GRN: if (done) state_next = NS_YEL;
`ifdef TRAFFIC_LIGHT_ALLRED_EN
            NS_YEL: if (done) state_next = NS_CLR;
            NS_CLR: if (done) state_next = WE_GRN;
            WE_GRN: if (done) state_next = WE_YEL;
            WE_YEL: if (done) state_next = WE_CLR;
            WE_CLR: if (done) state_next = NS_GRN;
`else
            NS_YEL: if (done) state_next = WE_GRN;
            WE_GRN: if (done) state_next = WE_YEL;
            WE_YEL: if (done) state_next = NS_GRN;
`endif
            // Illegal encodings (and clear states when they are not built)
            // restart the cycle cleanly.
            default: begin
                state_next = NS_GRN;
                count_next = '0;
            end
        endcase
    end

    // Both roads default to red so any non-green/yellow state is all-red.
    always_comb begin
        lightNS = LAMP_RED;
        lightWE = LAMP_RED;
        case (state)
            NS_GRN:  lightNS = LAMP_GRN;
            NS_YEL:  lightNS = LAMP_YEL;
            WE_GRN:  lightWE = LAMP_GRN;
            WE_YEL:  lightWE = LAMP_YEL;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_light_controller.sv
// tb/tb_traffic_light_controller.sv - randomized bench for traffic_light_controller
module tb_traffic_light_controller;

`ifdef TRAFFIC_LIGHT_ALLRED_EN
    localparam bit ALLRED = 1'b1;
`else
    localparam bit ALLRED = 1'b0;
`endif
    localparam int P_A   = ALLRED ? 74 : 70;
    localparam int LONG  = 20000;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] light_we_a;
    logic [2:0] light_ns_a;
    logic [2:0] light_we_b;
    logic [2:0] light_ns_b;

    int checks = 0;
    int errors = 0;
    int t      = 0;
    int cyc    = 0;
    bit valid  = 1'b0;

    bit         track      = 1'b0;
    int         last_onset = -1;
    int         ns_g       = 0;
    int         we_g       = 0;
    int         n_periods  = 0;
    logic [2:0] prev_ns    = 3'b000;

    always #5 clk = ~clk;

    traffic_light_controller dut_a (
        .clk     (clk),
        .rst     (rst),
        .lightWE (light_we_a),
        .lightNS (light_ns_a)
    );

    traffic_light_controller #(
        .GREEN_TIME  (3),
        .YELLOW_TIME (1),
        .ALLRED_TIME (1)
    ) dut_b (
        .clk     (clk),
        .rst     (rst),
        .lightWE (light_we_b),
        .lightNS (light_ns_b)
    );

    // Lamps {ns, we} at time t since reset, from the phase table alone.
    function automatic logic [5:0] model(input int tt, input int g, input int y, input int a);
        int gg, yy, aa, half, p, q;
        logic [2:0] lamp;
        gg   = (g < 1) ? 1 : g;
        yy   = (y < 1) ? 1 : y;
        aa   = ALLRED ? ((a < 1) ? 1 : a) : 0;
        half = gg + yy + aa;
        p    = tt % (2 * half);
        q    = p % half;
        if (q < gg)           lamp = 3'b001;
        else if (q < gg + yy) lamp = 3'b010;
        else                  lamp = 3'b100;
        return (p >= half) ? {3'b100, lamp} : {lamp, 3'b100};
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s t=%0d cyc=%0d got %0h expected %0h", tag, t, cyc, observed, expected);
        end
    endtask

    task automatic check_all();
        logic [5:0] m;
        m = model(t, 30, 5, 2);
        check("a_ns", light_ns_a, m[5:3]);
        check("a_we", light_we_a, m[2:0]);
        check("a_red", light_ns_a[2] | light_we_a[2], 1);
        check("a_onehot_ns", $onehot(light_ns_a), 1);
        check("a_onehot_we", $onehot(light_we_a), 1);
        m = model(t, 3, 1, 1);
        check("b_ns", light_ns_b, m[5:3]);
        check("b_we", light_we_b, m[2:0]);
        check("b_red", light_ns_b[2] | light_we_b[2], 1);
        check("b_onehot_ns", $onehot(light_ns_b), 1);
        check("b_onehot_we", $onehot(light_we_b), 1);
    endtask

    task automatic track_period();
        if (light_ns_a == 3'b001 && prev_ns != 3'b001) begin
            if (last_onset >= 0) begin
                check("period", cyc - last_onset, P_A);
                check("ns_green_cnt", ns_g, 30);
                check("we_green_cnt", we_g, 30);
                n_periods++;
            end
            last_onset = cyc;
            ns_g = 0;
            we_g = 0;
        end
        if (light_ns_a == 3'b001) ns_g++;
        if (light_we_a == 3'b001) we_g++;
    endtask

    // One clock: drive rst, advance the reference time at the edge,
    // then sample on the falling edge.
    task automatic cycle(input logic r);
        rst = r;
        @(posedge clk);
        if (r) begin
            t = 0;
            valid = 1'b1;
        end else begin
            t++;
        end
        cyc++;
        @(negedge clk);
        if (valid) begin
            check_all();
            if (track) track_period();
        end
        prev_ns = light_ns_a;
    endtask

    initial begin
        rst = 1'b1;

        // Reset then one full sequence plus a few cycles.
        cycle(1'b1);
        check("rst_ns", light_ns_a, 3'b001);
        check("rst_we", light_we_a, 3'b100);
        repeat (P_A + 5) cycle(1'b0);

        // Reset during WE green at cycle 50.
        cycle(1'b1);
        repeat (50) cycle(1'b0);
        check("pre_mid_we", light_we_a, 3'b001);
        cycle(1'b1);
        check("mid_rst_ns", light_ns_a, 3'b001);
        check("mid_rst_we", light_we_a, 3'b100);
        repeat (29) cycle(1'b0);
        check("mid_last_green", light_ns_a, 3'b001);
        cycle(1'b0);
        check("mid_yellow", light_ns_a, 3'b010);

        // Reset held for 10 cycles.
        repeat (10) begin
            cycle(1'b1);
            check("hold_ns", light_ns_a, 3'b001);
            check("hold_we", light_we_a, 3'b100);
            check("hold_b_ns", light_ns_b, 3'b001);
        end

        // Long free run with period and green-count tracking.
        track = 1'b1;
        repeat (LONG) cycle(1'b0);
        track = 1'b0;
        check("period_count", n_periods, LONG / P_A - 1);

        // Random reset pulses.
        repeat (3000) begin
            if ($urandom_range(0, 199) == 0) begin
                repeat ($urandom_range(1, 4)) cycle(1'b1);
            end else begin
                cycle(1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
